// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch stage: branch-type codes,
// reset PC, PC stride and the fetch state enum.
package busca_pkg;

    typedef enum logic [2:0] {
        DESVIO_NENHUM = 3'b000,
        DESVIO_BEQ    = 3'b001,
        DESVIO_BNE    = 3'b010,
        DESVIO_J      = 3'b011,
        DESVIO_JAL    = 3'b100
    } desvio_e;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam logic [31:0] PC_PASSO = 32'd4;

    typedef enum logic [1:0] {
        BUSCA,
        ESPERA,
        DESCARTE
    } estado_e;

endpackage

// File: rtl/busca_instrucao_proximo_pc.sv
// Combinational branch-resolution decode and next-PC selection for the
// fetch stage; holds no state.
module proximo_pc
    import busca_pkg::*;
(
    input  logic        desvio_valido,
    input  logic [2:0]  c_desvio,
    input  logic        zero,
    input  logic [31:0] alvo_desvio,
    input  logic [31:0] pc,
    output logic        tomado,
    output logic [31:0] pc_seq,
    output logic [31:0] pc_redir
);

    logic condicao;

    always_comb begin
        // NOTE: default assigned first so every path drives condicao and no latch is inferred.
        condicao = 1'b0;
        case (c_desvio)
            DESVIO_BEQ:           condicao = zero;
            DESVIO_BNE:           condicao = ~zero;
            DESVIO_J, DESVIO_JAL: condicao = 1'b1;
            default:              condicao = 1'b0;
        endcase
    end

    assign tomado   = desvio_valido & condicao;
    assign pc_seq   = pc + PC_PASSO;
    assign pc_redir = tomado ? alvo_desvio : pc;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: BUSCA/ESPERA/DESCARTE controller with branch redirect.
// Define BUSCA_CONTADOR_EN to add the contador_instr transfer counter output.
module busca_instrucao
    import busca_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_endereco,
    input  logic [31:0] mem_dado,
    input  logic        mem_ack,
    output logic [31:0] instrucao,
    output logic [31:0] pc_mais4,
    output logic        valido,
    input  logic        pronto,
    input  logic        desvio_valido,
    input  logic [2:0]  c_desvio,
    input  logic        zero,
    input  logic [31:0] alvo_desvio
`ifdef BUSCA_CONTADOR_EN
    ,
    output logic [31:0] contador_instr
`endif
);

    estado_e     estado;
    logic [31:0] pc;
    logic        tomado;
    logic [31:0] pc_seq;
    logic [31:0] pc_redir;

    proximo_pc u_proximo_pc (
        .desvio_valido (desvio_valido),
        .c_desvio      (c_desvio),
        .zero          (zero),
        .alvo_desvio   (alvo_desvio),
        .pc            (pc),
        .tomado        (tomado),
        .pc_seq        (pc_seq),
        .pc_redir      (pc_redir)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= BUSCA;
            pc           <= PC_RESET;
            mem_req      <= 1'b0;
            mem_endereco <= PC_RESET;
            instrucao    <= 32'h0;
            pc_mais4     <= 32'h0;
            valido       <= 1'b0;
        end else begin
            case (estado)
                BUSCA: begin
                    // mem_req is low here only on the first cycle after reset
                    if (!mem_req) begin
                        mem_req      <= 1'b1;
                        mem_endereco <= pc_redir;
                        pc           <= pc_redir;
                    end else if (mem_ack) begin
                        if (tomado) begin
                            pc           <= alvo_desvio;
                            mem_endereco <= alvo_desvio;
                        end else begin
                            instrucao <= mem_dado;
                            pc_mais4  <= pc_seq;
                            pc        <= pc_seq;
                            valido    <= 1'b1;
                            mem_req   <= 1'b0;
                            estado    <= ESPERA;
                        end
                    end else if (tomado) begin
                        pc     <= alvo_desvio;
                        estado <= DESCARTE;
                    end
                end
                ESPERA: begin
                    // a redirect here also completes any coincident transfer
                    if (tomado || pronto) begin
                        valido       <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_endereco <= pc_redir;
                        pc           <= pc_redir;
                        estado       <= BUSCA;
                    end
                end
                DESCARTE: begin
                    if (mem_ack) begin
                        mem_endereco <= pc_redir;
                        pc           <= pc_redir;
                        estado       <= BUSCA;
                    end else if (tomado) begin
                        pc <= alvo_desvio;
                    end
                end
                default: estado <= BUSCA;
            endcase
        end
    end

`ifdef BUSCA_CONTADOR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador_instr <= 32'h0;
        end else if (estado == ESPERA && valido && pronto) begin
            contador_instr <= contador_instr + 32'd1;
        end
    end
`endif

endmodule
